// File: rtl/display_scan.sv
// display_scan: consumer end of the watch's time_data bus.
//
// Takes the packed binary time word {hour[17:12], minute[11:6], second[5:0]}
// plus the PM and alarm flags, converts each field to two BCD digits and
// scans them onto a 6-digit multiplexed 7-segment display, one digit per
// scan slot. A whole frame is drawn from one snapshot of the inputs, the
// hour-tens digit is blanked when zero and the digit enables blink while the
// alarm is firing.
//
// Optional build macro: HOUR12_EN -- show the hour field in 12-hour form
// (0 -> 12, 13..23 -> hour-12). Undefined: raw 0..23 is shown.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-low reset
//   time_data   packed binary time from the control block
//   am_pm_div   1 = PM, shown on the decimal point of the hour-ones digit
//   alerm_equal 1 = alarm firing, blinks the whole display
//   seg         segments {g,f,e,d,c,b,a}, active-high
//   dp          decimal point, active-high
//   digit_sel   active-low digit enables, one-hot-low while scanning

module display_scan #(
  parameter int time_width = 18,
  parameter int scan_div   = 1000,
  parameter int blink_div  = 500000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [time_width-1:0] time_data,
  input  logic                  am_pm_div,
  input  logic                  alerm_equal,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [5:0]            digit_sel
);

  localparam int scan_w  = (scan_div  > 1) ? $clog2(scan_div)  : 1;
  localparam int blink_w = (blink_div > 1) ? $clog2(blink_div) : 1;
  localparam logic [scan_w-1:0]  scan_max  = scan_w'(scan_div - 1);
  localparam logic [blink_w-1:0] blink_max = blink_w'(blink_div - 1);

  logic [scan_w-1:0]     scan_cnt;
  logic [2:0]            idx;
  logic                  running;
  logic [time_width-1:0] snap_time;
  logic                  snap_pm;
  logic [5:0]            sel_base;

  logic [blink_w-1:0]    blink_cnt;
  logic                  blink_on;
  logic                  alarm_q;

  logic                  tick;
  logic [2:0]            idx_next;
  logic                  load_frame;
  logic [time_width-1:0] src_time;
  logic                  src_pm;
  logic [5:0]            field_raw;
  logic [5:0]            field_limit;
  logic [5:0]            field_disp;
  logic [5:0]            tens;
  logic [5:0]            ones;
  logic [5:0]            digit;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [5:0]            sel_next;
  logic [blink_w-1:0]    blink_cnt_next;
  logic                  blink_on_next;
  logic                  blank;

  function automatic logic [6:0] seg_code(input logic [5:0] d);
    case (d)
      6'd0:    seg_code = 7'h3F;
      6'd1:    seg_code = 7'h06;
      6'd2:    seg_code = 7'h5B;
      6'd3:    seg_code = 7'h4F;
      6'd4:    seg_code = 7'h66;
      6'd5:    seg_code = 7'h6D;
      6'd6:    seg_code = 7'h7D;
      6'd7:    seg_code = 7'h07;
      6'd8:    seg_code = 7'h7F;
      6'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  assign tick       = (scan_cnt == scan_max);
  // The first tick after reset loads index 0; later ticks advance and wrap.
  assign idx_next   = (!running || idx == 3'd5) ? 3'd0 : idx + 3'd1;
  assign load_frame = tick && (idx_next == 3'd0);
  // Index 0 is decoded straight from the inputs being captured, so the
  // whole frame comes from the same snapshot.
  assign src_time   = load_frame ? time_data : snap_time;
  assign src_pm     = load_frame ? am_pm_div : snap_pm;
  assign sel_next   = tick ? ~(6'b000001 << idx_next) : sel_base;

  // Decode of the digit that the next tick will load.
  always_comb begin
    field_raw   = 6'd0;
    field_limit = 6'd59;
    case (idx_next[2:1])
      2'd0:    field_raw = src_time[5:0];
      2'd1:    field_raw = src_time[11:6];
      default: begin
        field_raw   = src_time[17:12];
        field_limit = 6'd23;
      end
    endcase
    field_disp = field_raw;
`ifdef HOUR12_EN
    if (idx_next[2:1] == 2'd2) begin
      if (field_raw == 6'd0)
        field_disp = 6'd12;
      else if (field_raw > 6'd12)
        field_disp = field_raw - 6'd12;
    end
`else
`endif
    tens  = field_disp / 6'd10;
    ones  = field_disp % 6'd10;
    digit = idx_next[0] ? tens : ones;
    // Range is judged on the raw field, blanking on the displayed value.
    if (field_raw > field_limit)
      seg_next = 7'h40;
    else if (idx_next == 3'd5 && tens == 6'd0)
      seg_next = 7'h00;
    else
      seg_next = seg_code(digit);
    dp_next = (idx_next == 3'd4) && src_pm;
  end

  // Blink phase. The counter only starts running the cycle after the alarm
  // is first seen, so the opening off phase lasts a full blink_div cycles.
  // Gating uses the phase being written this edge, so a toggle and a scan
  // tick on the same edge both take effect together.
  always_comb begin
    blink_cnt_next = blink_cnt;
    blink_on_next  = blink_on;
    if (!alerm_equal) begin
      blink_cnt_next = '0;
      blink_on_next  = 1'b0;
    end else if (alarm_q) begin
      if (blink_cnt == blink_max) begin
        blink_cnt_next = '0;
        blink_on_next  = ~blink_on;
      end else begin
        blink_cnt_next = blink_cnt + 1'b1;
      end
    end
    blank = alerm_equal && !blink_on_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      idx       <= 3'd0;
      running   <= 1'b0;
      snap_time <= '0;
      snap_pm   <= 1'b0;
      sel_base  <= 6'b111111;
      seg       <= 7'h00;
      dp        <= 1'b0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
      sel_base <= sel_next;
      if (tick) begin
        idx     <= idx_next;
        running <= 1'b1;
        seg     <= seg_next;
        dp      <= dp_next;
      end
      if (load_frame) begin
        snap_time <= time_data;
        snap_pm   <= am_pm_div;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
      alarm_q   <= 1'b0;
      digit_sel <= 6'b111111;
    end else begin
      blink_cnt <= blink_cnt_next;
      blink_on  <= blink_on_next;
      alarm_q   <= alerm_equal;
      digit_sel <= blank ? 6'b111111 : sel_next;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with scan_div=4 and blink_div=8.
// Each test task starts while the first cycle of index 5 is on show, so new
// inputs are captured by the next index-0 tick.

module tb_display_scan;

  localparam int scan_div  = 4;
  localparam int blink_div = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] time_data = '0;
  logic        am_pm_div = 1'b0;
  logic        alerm_equal = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  digit_sel;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  display_scan #(
    .time_width(18),
    .scan_div  (scan_div),
    .blink_div (blink_div)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .time_data  (time_data),
    .am_pm_div  (am_pm_div),
    .alerm_equal(alerm_equal),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel)
  );

  function automatic logic [17:0] pack(input int h, input int m, input int s);
    logic [5:0] hh, mm, ss;
    hh = h[5:0];
    mm = m[5:0];
    ss = s[5:0];
    return {hh, mm, ss};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    time_data = pack(13, 45, 7);
    am_pm_div = 1'b1;
    #3 reset = 1'b0;
    #10;
    compared++;
    if (seg !== 7'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_seg: got %h want 00", seg);
    end
    compared++;
    if (dp !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_dp: got %b want 0", dp);
    end
    compared++;
    if (digit_sel !== 6'b111111) begin
      mismatched++;
      $display("[TB] FAIL reset_sel: got %b want 111111", digit_sel);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic_frame;
    logic [6:0] es [6];
    logic [5:0] exp_sel;
`ifdef HOUR12_EN
    es = '{7'h07, 7'h3F, 7'h6D, 7'h66, 7'h06, 7'h00};
`else
    es = '{7'h07, 7'h3F, 7'h6D, 7'h66, 7'h4F, 7'h06};
`endif
    for (int i = 0; i < 6; i++) begin
      step(4);
      exp_sel = ~(6'b000001 << i);
      compared++;
      if (seg !== es[i]) begin
        mismatched++;
        $display("[TB] FAIL basic_seg idx%0d: got %h want %h", i, seg, es[i]);
      end
      compared++;
      if (digit_sel !== exp_sel) begin
        mismatched++;
        $display("[TB] FAIL basic_sel idx%0d: got %b want %b", i, digit_sel, exp_sel);
      end
      compared++;
      if (dp !== (i == 4)) begin
        mismatched++;
        $display("[TB] FAIL basic_dp idx%0d: got %b want %b", i, dp, (i == 4));
      end
    end
  endtask

  task automatic test_blanking;
    logic [17:0] td [3];
    logic        pm [3];
    logic [6:0]  es [3][6];
    logic [5:0]  exp_sel;
    td = '{pack(5, 0, 0), pack(0, 0, 0), pack(23, 59, 59)};
    pm = '{1'b0, 1'b0, 1'b1};
`ifdef HOUR12_EN
    es = '{'{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h6D, 7'h00},
           '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h5B, 7'h06},
           '{7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h06, 7'h06}};
`else
    es = '{'{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h6D, 7'h00},
           '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00},
           '{7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h4F, 7'h5B}};
`endif
    for (int f = 0; f < 3; f++) begin
      time_data = td[f];
      am_pm_div = pm[f];
      for (int i = 0; i < 6; i++) begin
        step(4);
        exp_sel = ~(6'b000001 << i);
        compared++;
        if (seg !== es[f][i]) begin
          mismatched++;
          $display("[TB] FAIL blank_seg f%0d idx%0d: got %h want %h", f, i, seg, es[f][i]);
        end
        compared++;
        if (digit_sel !== exp_sel) begin
          mismatched++;
          $display("[TB] FAIL blank_sel f%0d idx%0d: got %b want %b", f, i, digit_sel, exp_sel);
        end
        compared++;
        if (dp !== (pm[f] && i == 4)) begin
          mismatched++;
          $display("[TB] FAIL blank_dp f%0d idx%0d: got %b want %b", f, i, dp, (pm[f] && i == 4));
        end
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [17:0] td [2];
    logic [6:0]  es [2][6];
    td = '{pack(10, 63, 59), pack(24, 59, 60)};
    es = '{'{7'h6F, 7'h6D, 7'h40, 7'h40, 7'h3F, 7'h06},
           '{7'h40, 7'h40, 7'h6F, 7'h6D, 7'h40, 7'h40}};
    am_pm_div = 1'b0;
    for (int f = 0; f < 2; f++) begin
      time_data = td[f];
      for (int i = 0; i < 6; i++) begin
        step(4);
        compared++;
        if (seg !== es[f][i]) begin
          mismatched++;
          $display("[TB] FAIL range_seg f%0d idx%0d: got %h want %h", f, i, seg, es[f][i]);
        end
      end
    end
  endtask

  task automatic test_snapshot;
    logic [6:0] es [12];
    logic       ed [12];
    es = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06,
           7'h07, 7'h5B, 7'h6F, 7'h06, 7'h7F, 7'h00};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    time_data = pack(12, 34, 56);
    am_pm_div = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(4);
      compared++;
      if (seg !== es[k]) begin
        mismatched++;
        $display("[TB] FAIL snap_seg slot%0d: got %h want %h", k, seg, es[k]);
      end
      compared++;
      if (dp !== ed[k]) begin
        mismatched++;
        $display("[TB] FAIL snap_dp slot%0d: got %b want %b", k, dp, ed[k]);
      end
      if (k == 2) begin
        time_data = pack(8, 19, 27);
        am_pm_div = 1'b1;
      end
    end
  endtask

  task automatic test_blink;
    logic [6:0] es [6];
    logic [5:0] exp_sel;
    int         idx;
    bit         gated;
    es = '{7'h07, 7'h5B, 7'h6F, 7'h06, 7'h7F, 7'h00};
    alerm_equal = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      idx     = (5 + k / 4) % 6;
      gated   = (((k - 1) / 8) % 2) == 0;
      exp_sel = gated ? 6'b111111 : ~(6'b000001 << idx);
      compared++;
      if (digit_sel !== exp_sel) begin
        mismatched++;
        $display("[TB] FAIL blink_sel cyc%0d: got %b want %b", k, digit_sel, exp_sel);
      end
      compared++;
      if (seg !== es[idx]) begin
        mismatched++;
        $display("[TB] FAIL blink_seg cyc%0d: got %h want %h", k, seg, es[idx]);
      end
    end
    alerm_equal = 1'b0;
    step(1);
    compared++;
    if (digit_sel !== 6'b110111) begin
      mismatched++;
      $display("[TB] FAIL blink_release: got %b want 110111", digit_sel);
    end
    step(7);
  endtask

  task automatic test_reset_mid_frame;
    logic [6:0] es [6];
    logic [5:0] exp_sel;
`ifdef HOUR12_EN
    es = '{7'h3F, 7'h4F, 7'h07, 7'h3F, 7'h6F, 7'h00};
`else
    es = '{7'h3F, 7'h4F, 7'h07, 7'h3F, 7'h06, 7'h5B};
`endif
    step(16);
    compared++;
    if (digit_sel !== 6'b110111) begin
      mismatched++;
      $display("[TB] FAIL mid_idx3: got %b want 110111", digit_sel);
    end
    #2 reset = 1'b0;
    #1;
    compared++;
    if (seg !== 7'h00 || dp !== 1'b0 || digit_sel !== 6'b111111) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got seg %h dp %b sel %b want 00 0 111111", seg, dp, digit_sel);
    end
    time_data = pack(21, 7, 30);
    am_pm_div = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    step(3);
    compared++;
    if (digit_sel !== 6'b111111 || seg !== 7'h00) begin
      mismatched++;
      $display("[TB] FAIL mid_pre_tick: got sel %b seg %h want 111111 00", digit_sel, seg);
    end
    for (int i = 0; i < 6; i++) begin
      step((i == 0) ? 1 : 4);
      exp_sel = ~(6'b000001 << i);
      compared++;
      if (seg !== es[i]) begin
        mismatched++;
        $display("[TB] FAIL mid_seg idx%0d: got %h want %h", i, seg, es[i]);
      end
      compared++;
      if (digit_sel !== exp_sel) begin
        mismatched++;
        $display("[TB] FAIL mid_sel idx%0d: got %b want %b", i, digit_sel, exp_sel);
      end
      compared++;
      if (dp !== (i == 4)) begin
        mismatched++;
        $display("[TB] FAIL mid_dp idx%0d: got %b want %b", i, dp, (i == 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_blanking();
    test_out_of_range();
    test_snapshot();
    test_blink();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
